// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared op encodings, FSM states and helpers for the memory-stage unit
package mips_mem_pkg;

  localparam int DEF_MEM_LAT = 2;
  localparam int DEF_DEPTH   = 40;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  function automatic logic is_load(input mem_op_e op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  // Misaligned halfword/word or word index beyond the end of data memory.
  function automatic logic access_err(input mem_op_e op, input logic [31:0] addr, input int depth);
    logic bad_align;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad_align = addr[0];
      OP_LW, OP_SW:         bad_align = |addr[1:0];
      default:              bad_align = 1'b0;
    endcase
    return bad_align || ({2'b00, addr[31:2]} >= $unsigned(depth));
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// rtl/load_align_ext.sv - big-endian byte/halfword select with sign or zero extension
module load_align_ext
  import mips_mem_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Offset 0 is the most significant byte/halfword of the word.
  always_comb begin
    sel_byte = 8'h00;
    case (offset)
      2'd0: sel_byte = word[31:24];
      2'd1: sel_byte = word[23:16];
      2'd2: sel_byte = word[15:8];
      2'd3: sel_byte = word[7:0];
      default: sel_byte = 8'h00;
    endcase
    sel_half = offset[1] ? word[15:0] : word[31:16];
  end

  // Extend the selected field according to the load flavour; non-loads yield zero.
  always_comb begin
    data = 32'h0;
    case (op)
      OP_LB:   data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  data = {24'h0, sel_byte};
      OP_LH:   data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  data = {16'h0, sel_half};
      OP_LW:   data = word;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit between EX/MEM and word-addressed data memory
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rdest,
  output logic        resp_valid,
  output logic        resp_we,
  output logic [4:0]  resp_rdest,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_rd,
  output logic        mem_wr
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  state_e        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  mem_op_e       op_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [4:0]    rdest_q;
  logic          err_q;
  logic          accept, capture, req_err;
  logic [31:0]   load_data, merged;

  assign req_err = access_err(mem_op_e'(req_op), req_addr, DEPTH);
  assign accept  = (state == ST_IDLE) && req_valid;

  // State and strobe-window down-counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state, strobes and completion pulse.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    capture    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          cnt_n = CNT_INIT;
          if (req_err)                              state_n = ST_RESP;
          else if (is_load(mem_op_e'(req_op)))      state_n = ST_RD;
          else if (mem_op_e'(req_op) == OP_SW)      state_n = ST_WR;
          else                                      state_n = ST_RMW_RD;
        end
      end
      ST_RD, ST_RMW_RD: begin
        mem_rd = 1'b1;
        if (cnt == '0) begin
          capture = 1'b1;
          cnt_n   = CNT_INIT;
          state_n = (state == ST_RD) ? ST_RESP : ST_RMW_WR;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_WR, ST_RMW_WR: begin
        mem_wr = 1'b1;
        if (cnt == '0) state_n = ST_RESP;
        else           cnt_n   = cnt - 1'b1;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_n    = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Request latch at accept and read-word capture on the last read cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= OP_LB;
      addr_q  <= '0;
      wdata_q <= '0;
      rdest_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= mem_op_e'(req_op);
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdest_q <= req_rdest;
        err_q   <= req_err;
      end
      if (capture) rdata_q <= mem_rdata;
    end
  end

  // Sub-word store merge into the captured word, big-endian lane placement.
  always_comb begin
    merged = rdata_q;
    if (op_q == OP_SB) begin
      case (addr_q[1:0])
        2'd0: merged[31:24] = wdata_q[7:0];
        2'd1: merged[23:16] = wdata_q[7:0];
        2'd2: merged[15:8]  = wdata_q[7:0];
        2'd3: merged[7:0]   = wdata_q[7:0];
        default: merged = rdata_q;
      endcase
    end else if (op_q == OP_SH) begin
      if (addr_q[1]) merged[15:0]  = wdata_q[15:0];
      else           merged[31:16] = wdata_q[15:0];
    end
  end

  load_align_ext u_load_align_ext (
    .op     (op_q),
    .offset (addr_q[1:0]),
    .word   (rdata_q),
    .data   (load_data)
  );

  assign req_ready  = rst_n && (state == ST_IDLE);
  assign mem_addr   = {2'b00, addr_q[31:2]};
  assign mem_wdata  = (state == ST_WR)     ? wdata_q :
                      (state == ST_RMW_WR) ? merged  : 32'h0;
  assign resp_rdest = rdest_q;
  assign resp_err   = (state == ST_RESP) && err_q;
  assign resp_we    = (state == ST_RESP) && is_load(op_q) && !err_q;
  assign resp_rdata = resp_we ? load_data : 32'h0;

endmodule
